signed_spm_core: RTL

- Parametrised signed/unsigned serial-parallel multiplier.
- Multiplicand is held in parallel. Multiplier is consumed one bit per clock, LSB first, with a shift-add datapath.
- Generalises the fixed 8-bit board multiplier:
  - WIDTH parameter
  - runtime two's-complement/unsigned mode
  - busy flag
  - single-cycle done pulse
- Sits between the board wrapper (switches/buttons/LEDs) and any future MAC or filter datapath.

---
 rtl/spm_pkg.sv | 26 ++
 rtl/spm_shift_add.sv | 52 +++++
 rtl/signed_spm_core.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier.
// Holds the FSM state encoding and the operand sign/zero-extend helper.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the extend helper handles; WIDTH must not exceed this.
  localparam int unsigned SPM_MAX_W = 64;

  // Extend the low w bits of v to a wider value: sign-extend when tc=1,
  // zero-extend when tc=0. Callers size-cast the result to WIDTH+1 bits.
  function automatic logic [SPM_MAX_W:0] ext_operand(input logic [SPM_MAX_W-1:0] v,
                                                     input int unsigned          w,
                                                     input logic                 tc);
    logic [SPM_MAX_W:0] mask;
    logic               fill;
    mask = {(SPM_MAX_W+1){1'b1}} << w;
    fill = tc & (|(v & (SPM_MAX_W'(1) << (w - 1))));
    return ({1'b0, v} & ~mask) | (fill ? mask : '0);
  endfunction

endpackage

// File: rtl/spm_shift_add.sv
// Partial-sum register with adder/subtractor for the serial-parallel
// multiplier. Each shift step adds (or subtracts) the extended multiplicand
// into the upper WIDTH+1 bits and shifts the 2*WIDTH+1-bit register right by
// one, arithmetically when tc=1, logically when tc=0.
module spm_shift_add
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               add_en,
  input  logic               sub_en,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH:0] p;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   sum;

  // Add/subtract the extended multiplicand into the upper part of the sum
  always_comb begin
    a_ext = (WIDTH+1)'(ext_operand(SPM_MAX_W'(a), WIDTH, tc));
    hi    = p[2*WIDTH:WIDTH];
    sum   = hi;
    if (sub_en) begin
      sum = hi - a_ext;
    end else if (add_en) begin
      sum = hi + a_ext;
    end
  end

  // Partial-sum register: clear on start, shift one multiplier bit per step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= '0;
    end else if (clr) begin
      p <= '0;
    end else if (shift) begin
      p <= {tc & sum[WIDTH], sum, p[WIDTH-1:1]};
    end
  end

  // The product always fits in the low 2*WIDTH bits
  assign result = p[2*WIDTH-1:0];

endmodule

// File: rtl/signed_spm_core.sv
// Signed/unsigned serial-parallel multiplier core.
// Optional feature macro: SPM_ACCUM_EN adds an 'acc' input; when set with
// start, the new result is added (mod 2^(2*WIDTH)) to the held product.
//
// Handshake: start is a level request sampled only in IDLE together with the
// operands; busy is high in RUN and DONE and any start seen then is ignored;
// done is a one-cycle pulse marking the cycle in which product first shows
// the new value, and product holds until the next completion.
module signed_spm_core
  import spm_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tc,
`ifdef SPM_ACCUM_EN
  input  logic               acc,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output state_t             state_dbg
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               tc_q;
`ifdef SPM_ACCUM_EN
  logic               acc_q;
`endif
  logic               last;
  logic               clr;
  logic               shift;
  logic               add_en;
  logic               sub_en;
  logic [2*WIDTH-1:0] result;

  assign last      = (count == CNT_W'(WIDTH-1));
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> RUN for WIDTH cycles -> DONE -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath controls; the MSB of a signed multiplier carries negative weight
  always_comb begin
    clr    = 1'b0;
    shift  = 1'b0;
    add_en = 1'b0;
    sub_en = 1'b0;
    busy   = (state != IDLE);
    case (state)
      IDLE: clr = start;
      RUN: begin
        shift  = 1'b1;
        add_en = b_q[0] & ~(last & tc_q);
        sub_en = b_q[0] & last & tc_q;
      end
      default: ;
    endcase
  end

  // Operand capture in IDLE; multiplier shifts right so b_q[0] is the live bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      tc_q  <= 1'b0;
      count <= '0;
`ifdef SPM_ACCUM_EN
      acc_q <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_q   <= a;
      b_q   <= b;
      tc_q  <= tc;
      count <= '0;
`ifdef SPM_ACCUM_EN
      acc_q <= acc;
`endif
    end else if (state == RUN) begin
      b_q   <= b_q >> 1;
      count <= count + CNT_W'(1);
    end
  end

  // Result register and done pulse, updated on the edge that leaves DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DONE) begin
`ifdef SPM_ACCUM_EN
        product <= acc_q ? (product + result) : result;
`else
        product <= result;
`endif
        done    <= 1'b1;
      end
    end
  end

  spm_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .shift  (shift),
    .add_en (add_en),
    .sub_en (sub_en),
    .tc     (tc_q),
    .a      (a_q),
    .result (result)
  );

endmodule
